// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use hazard unit.
// Entry tags are sized by FWD_REG_AW; instances may use any REG_AW up to it.
package fwd_pkg;

    localparam int FWD_REG_AW = 5;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] dst;
        logic                  reg_write;
        logic                  mem_read;
    } fwd_entry_t;

    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one EX operand against post-EX entries 1..FWD_DEPTH.
// Returns the nearest forwardable producer, or FWD_SEL_RF when none.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SELW      = 2
) (
    input  logic                     used,
    input  logic [REG_AW-1:0]        src,
    input  fwd_entry_t [FWD_DEPTH:1] ents,
    output logic [SELW-1:0]          sel
);

    logic [FWD_REG_AW-1:0] src_ext;

    assign src_ext = FWD_REG_AW'(src);

    always_comb begin
        sel = SELW'(FWD_SEL_RF);
        // Oldest first, so the nearest producer overwrites the result.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (used
                && src_ext != '0
                && ents[k].valid
                && ents[k].reg_write
                && ents[k].dst == src_ext
                && (!ents[k].mem_read || k >= LOAD_LAT + 1)) begin
                sel = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX forwarding selects and ID load-use stall from a private tag pipeline.
// Build option: define FWD_PERF_CNT_EN to add saturating stall/forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]               id_src_addr,
    input  logic [NUM_SRC-1:0]                      id_src_used,
    input  logic [REG_AW-1:0]                       id_dst_addr,
    input  logic                                    id_reg_write,
    input  logic                                    id_mem_read,
    input  logic                                    flush,
    output logic [NUM_SRC*sel_width(FWD_DEPTH)-1:0] fwd_sel,
    output logic                                    stall,
    output logic                                    bubble,
    output logic [31:0]                             stall_cnt,
    output logic [31:0]                             fwd_cnt
);

    localparam int SELW = sel_width(FWD_DEPTH);

    if (FWD_DEPTH < LOAD_LAT + 1) begin : g_bad_depth
        $error("fwd_hazard_unit: FWD_DEPTH must be >= LOAD_LAT+1");
    end
    if (REG_AW > FWD_REG_AW) begin : g_bad_aw
        $error("fwd_hazard_unit: REG_AW exceeds fwd_pkg::FWD_REG_AW");
    end

    fwd_entry_t [FWD_DEPTH:0]       ent;
    logic [NUM_SRC-1:0][REG_AW-1:0] ex_src;
    logic [NUM_SRC-1:0]             ex_used;
    logic [NUM_SRC-1:0][REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]             src_hit;
    logic                           id_take;

    assign id_src  = id_src_addr;
    assign id_take = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent     <= '0;
            ex_src  <= '0;
            ex_used <= '0;
        end else begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                ent[k+1] <= ent[k];
            end
            if (id_take) begin
                ent[0].valid     <= 1'b1;
                ent[0].dst       <= FWD_REG_AW'(id_dst_addr);
                ent[0].reg_write <= id_reg_write;
                ent[0].mem_read  <= id_mem_read;
                ex_src           <= id_src;
                ex_used          <= id_src_used;
            end else begin
                ent[0]  <= '0;
                ex_src  <= '0;
                ex_used <= '0;
            end
        end
    end

    // A load younger than LOAD_LAT stages cannot yet supply its data.
    always_comb begin
        src_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                if (id_src_used[i]
                    && id_src[i] != '0
                    && ent[k].valid
                    && ent[k].mem_read
                    && ent[k].reg_write
                    && ent[k].dst == FWD_REG_AW'(id_src[i])) begin
                    src_hit[i] = 1'b1;
                end
            end
        end
    end

    assign stall  = id_valid && !flush && (|src_hit);
    assign bubble = stall || flush;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_match #(
            .REG_AW   (REG_AW),
            .FWD_DEPTH(FWD_DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_match (
            .used(ex_used[i]),
            .src (ex_src[i]),
            .ents(ent[FWD_DEPTH:1]),
            .sel (fwd_sel[i*SELW +: SELW])
        );
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] fwd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else begin
            if (stall && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if ((|fwd_sel) && fwd_q != '1) begin
                fwd_q <= fwd_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign fwd_cnt   = fwd_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit in two configurations.
// Reference: a per-cycle issue log; selects/stalls derived from instruction ages.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int SW = 2;
`ifdef FWD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           id_valid = 1'b0;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS-1:0]  id_src_used = '0;
    logic [AW-1:0]  id_dst_addr = '0;
    logic           id_reg_write = 1'b0;
    logic           id_mem_read = 1'b0;
    logic           flush = 1'b0;

    logic [NS*SW-1:0] sel_a, sel_b;
    logic             stall_a, stall_b, bub_a, bub_b;
    logic [31:0]      sc_a, sc_b, fc_a, fc_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(2), .LOAD_LAT(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .fwd_sel(sel_a), .stall(stall_a), .bubble(bub_a),
        .stall_cnt(sc_a), .fwd_cnt(fc_a)
    );

    fwd_hazard_unit #(
        .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(3), .LOAD_LAT(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .fwd_sel(sel_b), .stall(stall_b), .bubble(bub_b),
        .stall_cnt(sc_b), .fwd_cnt(fc_b)
    );

    typedef struct packed {
        bit            v;
        bit [4:0]      dst;
        bit            wr;
        bit            ld;
        bit [1:0][4:0] src;
        bit [1:0]      used;
    } rec_t;

    // lg[c][n]: instruction that entered EX at clock edge n (config c)
    rec_t        lg [2][64];
    int          cyc = 0;
    int          floor_c = 0;
    bit          st_exp [2];
    bit          fw_exp [2];
    logic [31:0] sc_m [2];
    logic [31:0] fc_m [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int depth(input int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic int lat(input int c);
        return (c == 0) ? 1 : 2;
    endfunction

    function automatic rec_t age_rec(input int c, input int a);
        if (cyc - a <= floor_c) return '0;
        return lg[c][(cyc - a) & 63];
    endfunction

    function automatic int exp_sel(input int c, input int i);
        rec_t ex;
        rec_t r;
        ex = age_rec(c, 0);
        if (!ex.used[i] || ex.src[i] == 5'd0) return 0;
        for (int a = 1; a <= depth(c); a++) begin
            r = age_rec(c, a);
            if (r.v && r.wr && r.dst == ex.src[i] && (!r.ld || a >= lat(c) + 1))
                return a;
        end
        return 0;
    endfunction

    function automatic bit exp_stall(input int c);
        rec_t r;
        logic [4:0] s;
        if (!id_valid || flush) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = id_src_addr[i*5 +: 5];
            for (int a = 0; a < lat(c); a++) begin
                r = age_rec(c, a);
                if (id_src_used[i] && s != 5'd0 && r.v && r.ld && r.wr && r.dst == s)
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        logic [3:0]  sel;
        logic        st, bb;
        logic [31:0] sc, fc;
        int          e0, e1;
        string       sfx;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            sel = (c == 0) ? sel_a : sel_b;
            st  = (c == 0) ? stall_a : stall_b;
            bb  = (c == 0) ? bub_a : bub_b;
            sc  = (c == 0) ? sc_a : sc_b;
            fc  = (c == 0) ? fc_a : fc_b;
            sfx = (c == 0) ? "a" : "b";
            e0 = exp_sel(c, 0);
            e1 = exp_sel(c, 1);
            st_exp[c] = exp_stall(c);
            fw_exp[c] = (e0 != 0) || (e1 != 0);
            chk({"sel0_", sfx}, sel[1:0], e0);
            chk({"sel1_", sfx}, sel[3:2], e1);
            chk({"stall_", sfx}, st, st_exp[c]);
            chk({"bubble_", sfx}, bb, st_exp[c] || flush);
            chk({"stall_cnt_", sfx}, sc, PERF_ON ? sc_m[c] : 32'd0);
            chk({"fwd_cnt_", sfx}, fc, PERF_ON ? fc_m[c] : 32'd0);
        end
    endtask

    task automatic tick();
        rec_t r;
        @(posedge clk);
        cyc++;
        if (rst) floor_c = cyc;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                sc_m[c] = '0;
                fc_m[c] = '0;
            end else begin
                if (st_exp[c] && sc_m[c] != '1) sc_m[c]++;
                if (fw_exp[c] && fc_m[c] != '1) fc_m[c]++;
                r = '0;
                if (id_valid && !flush && !st_exp[c]) begin
                    r.v      = 1'b1;
                    r.dst    = id_dst_addr;
                    r.wr     = id_reg_write;
                    r.ld     = id_mem_read;
                    r.src[0] = id_src_addr[4:0];
                    r.src[1] = id_src_addr[9:5];
                    r.used   = id_src_used;
                end
                lg[c][cyc & 63] = r;
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] s0, input bit [4:0] s1,
                          input bit [1:0] u, input bit [4:0] d,
                          input bit w, input bit l);
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = u;
        id_dst_addr  = d;
        id_reg_write = w;
        id_mem_read  = l;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        sc_m = '{32'd0, 32'd0};
        fc_m = '{32'd0, 32'd0};
        st_exp = '{1'b0, 1'b0};
        fw_exp = '{1'b0, 1'b0};
        rst = 1'b1;
        idle();
        tick();
        tick();
        sample();
        chk("rst_sel_a", sel_a, 0);
        chk("rst_stall_a", stall_a, 0);
        chk("rst_bubble_b", bub_b, 0);
        tick();
        rst = 1'b0;

        // load-use: one stall in A, two in B
        set_id(1, 0, 0, 2'b00, 3, 1, 1); sample(); tick();
        set_id(1, 3, 0, 2'b01, 8, 1, 0);
        sample();
        chk("ldu_stall_a", stall_a, 1);
        chk("ldu_bubble_a", bub_a, 1);
        chk("ldu_stall_b", stall_b, 1);
        tick();
        sample();
        chk("ldu_stall_a2", stall_a, 0);
        chk("ldu_stall_b2", stall_b, 1);
        tick();
        sample();
        chk("ldu_sel_a", sel_a[1:0], 2);
        chk("ldu_stall_b3", stall_b, 0);
        tick();
        idle();
        sample();
        chk("ldu_sel_b", sel_b[1:0], 3);
        chk("ldu_cnt_a", sc_a, PERF_ON ? 32'd1 : 32'd0);
        chk("ldu_cnt_b", sc_b, PERF_ON ? 32'd2 : 32'd0);
        tick();

        // ALU back-to-back
        set_id(1, 0, 0, 2'b00, 5, 1, 0); sample(); tick();
        set_id(1, 5, 0, 2'b01, 6, 1, 0);
        sample();
        chk("alu_stall_a", stall_a, 0);
        tick();
        idle();
        sample();
        chk("alu_sel_a", sel_a[1:0], 1);
        chk("alu_sel_b", sel_b[1:0], 1);
        tick();

        // double write of r7: nearest producer wins
        set_id(1, 0, 0, 2'b00, 7, 1, 0); sample(); tick();
        sample(); tick();
        set_id(1, 7, 7, 2'b11, 9, 1, 0); sample(); tick();
        idle();
        sample();
        chk("dbl_sel_a", sel_a, 4'b0101);
        chk("dbl_sel_b", sel_b, 4'b0101);
        tick();

        // r0 and unused operands
        set_id(1, 0, 0, 2'b00, 0, 1, 0); sample(); tick();
        set_id(1, 0, 0, 2'b11, 10, 1, 0); sample(); tick();
        idle();
        sample();
        chk("r0_sel_a", sel_a, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 0, 1, 1); sample(); tick();
        set_id(1, 0, 0, 2'b11, 11, 1, 0);
        sample();
        chk("r0_stall_a", stall_a, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 4, 1, 1); sample(); tick();
        set_id(1, 4, 4, 2'b00, 12, 1, 0);
        sample();
        chk("unused_stall_a", stall_a, 0);
        chk("unused_stall_b", stall_b, 0);
        tick();

        // flush wins over stall; flushed instruction never issues
        set_id(1, 0, 0, 2'b00, 3, 1, 1); sample(); tick();
        set_id(1, 3, 0, 2'b01, 13, 1, 0);
        flush = 1'b1;
        sample();
        chk("fl_stall_a", stall_a, 0);
        chk("fl_bubble_a", bub_a, 1);
        tick();
        flush = 1'b0;
        set_id(1, 13, 0, 2'b01, 14, 1, 0); sample(); tick();
        idle();
        sample();
        chk("fl_sel_a", sel_a[1:0], 0);
        tick();

        // reset in the middle of a stall
        set_id(1, 0, 0, 2'b00, 3, 1, 1); sample(); tick();
        set_id(1, 3, 0, 2'b01, 15, 1, 0);
        sample();
        chk("mid_stall_a", stall_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        chk("mid_rst_stall_a", stall_a, 0);
        chk("mid_rst_bubble_a", bub_a, 0);
        chk("mid_rst_sel_b", sel_b, 0);
        chk("mid_rst_sc_a", sc_a, 0);
        chk("mid_rst_fc_b", fc_b, 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 99) < 85,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 35);
            sample();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
